// File: rtl/native_bus_router_pkg.sv
// Shared types and helpers for the native bus router: FSM state enum,
// default error read data, base/mask map entry and width derivations.
package native_bus_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_ERR
    } state_e;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

    // Map entries are held at the widest supported address width.
    localparam int MAP_W = 64;

    typedef struct packed {
        logic [MAP_W-1:0] base;
        logic [MAP_W-1:0] mask;
    } bus_map_t;

    function automatic logic map_hit(bus_map_t m, logic [MAP_W-1:0] a);
        return (a & m.mask) == m.base;
    endfunction

    // Timeout counter width: it must be able to hold TIMEOUT_CYC-1.
    function automatic int timeout_w(int cyc);
        return (cyc < 2) ? 1 : $clog2(cyc + 1);
    endfunction

    function automatic int sel_w(int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/native_bus_router_if.sv
// Core-side native bus plus the broadcast slave bus of the router.
// master: the core and slaves (testbench side); slave: the router itself.
interface native_bus_router_if #(
    parameter int N_SLV  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                      mem_valid;
    logic                      mem_instr;
    logic                      mem_ready;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W/8-1:0]       mem_wstrb;
    logic [DATA_W-1:0]         mem_rdata;

    logic [N_SLV-1:0]          slv_valid;
    logic                      slv_instr;
    logic [ADDR_W-1:0]         slv_addr;
    logic [DATA_W-1:0]         slv_wdata;
    logic [DATA_W/8-1:0]       slv_wstrb;
    logic [N_SLV-1:0]          slv_ready;
    logic [N_SLV*DATA_W-1:0]   slv_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
        output slv_ready, slv_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
        input  slv_ready, slv_rdata
    );

endinterface

// File: rtl/native_bus_router_decoder.sv
// bus_addr_decoder: combinational base/mask address decode.
// Ports: addr in; sel (matching slave index) and hit out. Lowest index wins.
module bus_addr_decoder
    import native_bus_router_pkg::*;
#(
    parameter int N_SLV  = 2,
    parameter int ADDR_W = 32,
    parameter int SEL_W  = 1,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  sel,
    output logic              hit
);

    bus_map_t map;

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        map = '0;
        sel = '0;
        hit = 1'b0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            map.base = MAP_W'(SLV_BASE[i*ADDR_W +: ADDR_W]);
            map.mask = MAP_W'(SLV_MASK[i*ADDR_W +: ADDR_W]);
            if (map_hit(map, MAP_W'(addr))) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/native_bus_router.sv
// native_bus_router: routes the picorv32 native bus to N_SLV slaves.
// Ports: clk, reset (sync, active-high), bus (slave modport of
// native_bus_router_if), bus_err pulse, err_addr, saturating err_cnt.
module native_bus_router
    import native_bus_router_pkg::*;
#(
    parameter int N_SLV       = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE =
        {32'h0001_0000, 32'h0000_0000},
    parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK =
        {32'hFFFF_0000, 32'hFFFF_0000},
    parameter int TIMEOUT_CYC = 256,
    parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_RDATA_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    native_bus_router_if.slave bus,
    output logic              bus_err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       err_cnt
);

    localparam int SEL_W    = sel_w(N_SLV);
    localparam int STRB_W   = DATA_W / 8;
    localparam int TMO_W    = timeout_w(TIMEOUT_CYC);
    localparam int TMO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                instr_q, instr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [15:0]         err_cnt_q, err_cnt_d;

    logic [SEL_W-1:0]    dec_sel;
    logic                dec_hit;
    logic                sel_ready;
    logic                tmo_hit;
    logic [15:0]         err_cnt_inc;

    logic [N_SLV-1:0]    slv_valid;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_rdata;
    logic                bus_err_o;

    bus_addr_decoder #(
        .N_SLV    (N_SLV),
        .ADDR_W   (ADDR_W),
        .SEL_W    (SEL_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr (bus.mem_addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    assign sel_ready   = bus.slv_ready[sel_q];
    assign tmo_hit     = (TIMEOUT_CYC != 0) && (tmo_q == TMO_W'(TMO_LAST));
    assign err_cnt_inc = (err_cnt_q == 16'hFFFF) ? err_cnt_q
                                                 : err_cnt_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            instr_q    <= 1'b0;
            rdata_q    <= '0;
            tmo_q      <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            instr_q    <= instr_d;
            rdata_q    <= rdata_d;
            tmo_q      <= tmo_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // err_addr/err_cnt update on entry to ERR so they are current
    // in the same cycle as the bus_err pulse.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        instr_d    = instr_q;
        rdata_d    = rdata_q;
        tmo_d      = tmo_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.mem_valid) begin
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    wstrb_d = bus.mem_wstrb;
                    instr_d = bus.mem_instr;
                    sel_d   = dec_sel;
                    tmo_d   = '0;
                    if (dec_hit) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d    = ST_ERR;
                        err_addr_d = bus.mem_addr;
                        err_cnt_d  = err_cnt_inc;
                    end
                end
            end
            ST_ACCESS: begin
                tmo_d = tmo_q + 1'b1;
                // A ready on the timeout edge still completes normally.
                if (sel_ready) begin
                    rdata_d = bus.slv_rdata[int'(sel_q)*DATA_W +: DATA_W];
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    state_d    = ST_ERR;
                    err_addr_d = addr_q;
                    err_cnt_d  = err_cnt_inc;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        slv_valid = '0;
        mem_ready = 1'b0;
        bus_err_o = 1'b0;
        mem_rdata = rdata_q;
        unique case (state_q)
            ST_ACCESS: slv_valid[sel_q] = 1'b1;
            ST_RESP:   mem_ready = 1'b1;
            ST_ERR: begin
                mem_ready = 1'b1;
                bus_err_o = 1'b1;
                mem_rdata = ERR_RDATA;
            end
            default: ;
        endcase
    end

    assign bus.slv_valid = slv_valid;
    assign bus.slv_instr = instr_q;
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;
    assign bus.slv_wstrb = wstrb_q;
    assign bus.mem_ready = mem_ready;
    assign bus.mem_rdata = mem_rdata;
    assign bus_err       = bus_err_o;
    assign err_addr      = err_addr_q;
    assign err_cnt       = err_cnt_q;

endmodule
